// File: rtl/srff_cnt_bank.sv
// srff_cnt_bank
//   Bank of NCH independent set/clear channels. Each channel is either a
//   set-dominant flag (MODE 0) or a saturating up/down counter that tracks
//   outstanding events (MODE 1).
//
// Parameters
//   NCH    number of channels, 1..32
//   CNT_W  per-channel counter width; counters saturate at 2^CNT_W-1
//   MODE   0 = flag mode, 1 = counting mode
//
// Ports
//   clk       clock; all state updates on the rising edge
//   rst       synchronous active-high reset
//   set       per-channel set / increment request
//   clr       per-channel clear / decrement request
//   err_clr   clears all sticky error flags
//   q         per-channel state (flag set, or count nonzero)
//   cnt       packed per-channel counts, channel i at [i*CNT_W +: CNT_W]
//   any_q     OR of all q bits
//   first_ch  lowest-numbered channel with q=1, 0 when none
//   ovf_err   sticky per-channel overflow flags (MODE 1 only)
//   unf_err   sticky per-channel underflow flags (MODE 1 only)
//
// Every output is a register or a function of registers only; set/clr
// never reach an output without passing through a flop.

module srff_cnt_bank #(
  parameter int NCH   = 4,
  parameter int CNT_W = 3,
  parameter int MODE  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH-1:0]       set,
  input  logic [NCH-1:0]       clr,
  input  logic                 err_clr,
  output logic [NCH-1:0]       q,
  output logic [NCH*CNT_W-1:0] cnt,
  output logic                 any_q,
  output logic [4:0]           first_ch,
  output logic [NCH-1:0]       ovf_err,
  output logic [NCH-1:0]       unf_err
);

  localparam logic [CNT_W-1:0] CMAX = '1;

  generate
    if (MODE == 0) begin : g_flag
      logic [NCH-1:0] flag_q;
      // Error flags have no meaning in flag mode; err_clr is tied off here.
      logic           unused_err_clr;

      assign unused_err_clr = err_clr;

      // Set dominates: a simultaneous clear is ignored.
      always_ff @(posedge clk) begin
        if (rst) begin
          flag_q <= '0;
        end else begin
          flag_q <= set | (flag_q & ~clr);
        end
      end

      assign q       = flag_q;
      assign cnt     = '0;
      assign ovf_err = '0;
      assign unf_err = '0;
    end else begin : g_count
      logic [NCH-1:0] inc;
      logic [NCH-1:0] dec;
      logic [NCH-1:0] ovf_evt;
      logic [NCH-1:0] unf_evt;
      logic [NCH-1:0] ovf_q;
      logic [NCH-1:0] unf_q;

      // Simultaneous set and clr cancel, so only the exclusive cases move
      // the counter.
      assign inc = set & ~clr;
      assign dec = clr & ~set;

      for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CNT_W-1:0] count_q;
        logic             at_max;
        logic             at_zero;

        assign at_max  = (count_q == CMAX);
        assign at_zero = (count_q == '0);

        assign ovf_evt[i] = inc[i] & at_max;
        assign unf_evt[i] = dec[i] & at_zero;

        always_ff @(posedge clk) begin
          if (rst) begin
            count_q <= '0;
          end else if (inc[i] && !at_max) begin
            count_q <= count_q + 1'b1;
          end else if (dec[i] && !at_zero) begin
            count_q <= count_q - 1'b1;
          end
        end

        assign q[i]                     = ~at_zero;
        assign cnt[i*CNT_W +: CNT_W]    = count_q;
      end

      // A fresh boundary event in the same cycle as err_clr survives the
      // clear, so no event is ever silently lost.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= '0;
          unf_q <= '0;
        end else if (err_clr) begin
          ovf_q <= ovf_evt;
          unf_q <= unf_evt;
        end else begin
          ovf_q <= ovf_q | ovf_evt;
          unf_q <= unf_q | unf_evt;
        end
      end

      assign ovf_err = ovf_q;
      assign unf_err = unf_q;
    end
  endgenerate

  assign any_q = |q;

  // Priority encode from the top down so the lowest set channel wins.
  always_comb begin
    first_ch = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (q[i]) begin
        first_ch = 5'(i);
      end
    end
  end

endmodule
